decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 193 +++++++++++++++++++
 tb/tb_decode_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: control decode, register file with write-through bypass,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_CNT   = 32,
    parameter bit ANDI_ZEXT = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc_plus_four_in,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_register,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [10:0]       ex_ctrl,
    output logic [31:0]       ex_pc_plus_four,
    output logic [31:0]       ex_pc_jump,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_immediate,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd
);

    localparam int AW = $clog2(REG_CNT);
    localparam logic [5:0] RCNT = 6'(REG_CNT);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic [10:0]       ctrl;
    logic              reads_rt;
    logic              is_andi;
    logic [DATA_W-1:0] imm;
    logic              wb_en;
    logic [4:0]        ra [2];
    logic [DATA_W-1:0] rdata [2];

    logic [DATA_W-1:0] rf_q [REG_CNT];
    logic [DATA_W-1:0] rf_d [REG_CNT];

    logic              ex_valid_q, ex_valid_d;
    logic [10:0]       ex_ctrl_q, ex_ctrl_d;
    logic [31:0]       ex_pc4_q, ex_pc4_d;
    logic [31:0]       ex_pcj_q, ex_pcj_d;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];

    // ctrl = {Jump, RegWrite, MemToReg, BNE, BEQ, MemRead, MemWrite, ALUOp, RegDst, ALUSrc}
    always_comb begin
        ctrl     = '0;
        reads_rt = 1'b0;
        is_andi  = 1'b0;
        if (instr_valid) begin
            unique case (opcode)
                OP_R: begin
                    ctrl     = 11'b011_0000_1010;
                    reads_rt = 1'b1;
                end
                OP_J:    ctrl = 11'b100_0000_0000;
                OP_BEQ: begin
                    ctrl     = 11'b000_0100_0100;
                    reads_rt = 1'b1;
                end
                OP_BNE: begin
                    ctrl     = 11'b000_1000_0100;
                    reads_rt = 1'b1;
                end
                OP_ADDI: ctrl = 11'b011_0000_0001;
                OP_ANDI: begin
                    ctrl    = 11'b011_0000_1101;
                    is_andi = 1'b1;
                end
                OP_LW:   ctrl = 11'b010_0010_0001;
                OP_SW: begin
                    ctrl     = 11'b000_0001_0001;
                    reads_rt = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    always_comb begin
        if (is_andi && ANDI_ZEXT)
            imm = {{(DATA_W-16){1'b0}}, instruction[15:0]};
        else
            imm = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    end

    assign wb_en = wb_reg_write && (wb_write_register != 5'd0)
                   && ({1'b0, wb_write_register} < RCNT);

    // Out-of-range and r0 addresses read as zero; same-cycle writeback bypasses.
    always_comb begin
        ra[0] = rs;
        ra[1] = rt;
        for (int i = 0; i < 2; i++) begin
            rdata[i] = '0;
            if (ra[i] != 5'd0 && {1'b0, ra[i]} < RCNT) begin
                if (wb_en && wb_write_register == ra[i])
                    rdata[i] = wb_write_data;
                else
                    rdata[i] = rf_q[ra[i][AW-1:0]];
            end
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en)
            rf_d[wb_write_register[AW-1:0]] = wb_write_data;
    end

    assign stall_out = !reset && ex_valid_q && ex_ctrl_q[5]
                       && (ex_rt_q != 5'd0)
                       && ((ex_rt_q == rs) || ((ex_rt_q == rt) && reads_rt));

    always_comb begin
        ex_valid_d = instr_valid && !flush && !stall_out;
        ex_ctrl_d  = (flush || stall_out) ? 11'd0 : ctrl;
        ex_pc4_d   = pc_plus_four_in;
        ex_pcj_d   = {pc_plus_four_in[31:28], instruction[25:0], 2'b00};
        ex_rd1_d   = rdata[0];
        ex_rd2_d   = rdata[1];
        ex_imm_d   = imm;
        ex_rs_d    = rs;
        ex_rt_d    = rt;
        ex_rd_d    = rd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_q       <= '{default: '0};
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_pc4_q   <= '0;
            ex_pcj_q   <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
        end else begin
            rf_q       <= rf_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_pcj_q   <= ex_pcj_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid        = ex_valid_q;
    assign ex_ctrl         = ex_ctrl_q;
    assign ex_pc_plus_four = ex_pc4_q;
    assign ex_pc_jump      = ex_pcj_q;
    assign ex_read_data_1  = ex_rd1_q;
    assign ex_read_data_2  = ex_rd2_q;
    assign ex_immediate    = ex_imm_q;
    assign ex_rs           = ex_rs_q;
    assign ex_rt           = ex_rt_q;
    assign ex_rd           = ex_rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random stimulus
// checked against an instruction-level reference model.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_plus_four_in = '0;
    logic [31:0] instruction = '0;
    logic        instr_valid = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_register = '0;
    logic [31:0] wb_write_data = '0;
    logic        flush = 1'b0;
    logic        stall_out;
    logic        ex_valid;
    logic [10:0] ex_ctrl;
    logic [31:0] ex_pc_plus_four, ex_pc_jump;
    logic [31:0] ex_read_data_1, ex_read_data_2, ex_immediate;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    int checks = 0;
    int failures = 0;
    logic last_stall;

    logic [31:0] ref_rf [32];
    logic        m_valid;
    logic [10:0] m_ctrl;
    logic [4:0]  m_rt;

    decode_stage dut (
        .clock(clock), .reset(reset),
        .pc_plus_four_in(pc_plus_four_in), .instruction(instruction),
        .instr_valid(instr_valid), .wb_reg_write(wb_reg_write),
        .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
        .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_pc_plus_four(ex_pc_plus_four),
        .ex_pc_jump(ex_pc_jump), .ex_read_data_1(ex_read_data_1),
        .ex_read_data_2(ex_read_data_2), .ex_immediate(ex_immediate),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_ctrl(input logic [5:0] op,
                                               input logic v);
        bit alusrc = 0, regdst = 0, memw = 0, memr = 0;
        bit beq = 0, bne = 0, m2r = 0, rw = 0, jmp = 0;
        bit [1:0] aluop = 2'b00;
        if (!v) return '0;
        case (op)
            6'h00: begin regdst = 1; aluop = 2'b10; m2r = 1; rw = 1; end
            6'h02: jmp = 1;
            6'h04: begin aluop = 2'b01; beq = 1; end
            6'h05: begin aluop = 2'b01; bne = 1; end
            6'h08: begin alusrc = 1; m2r = 1; rw = 1; end
            6'h0c: begin alusrc = 1; aluop = 2'b11; m2r = 1; rw = 1; end
            6'h23: begin alusrc = 1; memr = 1; rw = 1; end
            6'h2b: begin alusrc = 1; memw = 1; end
            default: ;
        endcase
        return {jmp, rw, m2r, bne, beq, memr, memw, aluop, regdst, alusrc};
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a,
        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return ref_rf[a];
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_ctrl = '0;
        m_rt = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, stall_out, 0);
        chk({tag, "_valid"}, ex_valid, 0);
        chk({tag, "_ctrl"}, ex_ctrl, 0);
        chk({tag, "_pc4"}, ex_pc_plus_four, 0);
        chk({tag, "_pcj"}, ex_pc_jump, 0);
        chk({tag, "_rd1"}, ex_read_data_1, 0);
        chk({tag, "_rd2"}, ex_read_data_2, 0);
        chk({tag, "_imm"}, ex_immediate, 0);
        chk({tag, "_rs"}, {ex_rs, ex_rt, ex_rd}, 0);
    endtask

    task automatic cycle(input logic [31:0] ins, input logic v,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic fl);
        logic [31:0] pc4;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        hz, e_valid;
        logic [10:0] e_ctrl;
        logic [31:0] e_rd1, e_rd2, e_imm, e_pcj;
        pc4 = $urandom;
        pc_plus_four_in = pc4;
        instruction = ins;
        instr_valid = v;
        wb_reg_write = we;
        wb_write_register = wa;
        wb_write_data = wd;
        flush = fl;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        #1;
        hz = m_valid && m_ctrl[5] && m_rt != 0
             && (m_rt == rs || (m_rt == rt && v && reads_rt(op)));
        chk("stall", stall_out, hz);
        last_stall = stall_out;
        e_rd1 = ref_read(rs, we, wa, wd);
        e_rd2 = ref_read(rt, we, wa, wd);
        if (v && op == 6'h0c) e_imm = {16'h0, ins[15:0]};
        else e_imm = {{16{ins[15]}}, ins[15:0]};
        e_pcj = {pc4[31:28], ins[25:0], 2'b00};
        e_valid = v && !fl && !hz;
        e_ctrl = (fl || hz) ? 11'd0 : model_ctrl(op, v);
        @(posedge clock);
        if (we && wa != 0) ref_rf[wa] = wd;
        #1;
        chk("ex_valid", ex_valid, e_valid);
        chk("ex_ctrl", ex_ctrl, e_ctrl);
        chk("ex_pc4", ex_pc_plus_four, pc4);
        chk("ex_pcj", ex_pc_jump, e_pcj);
        chk("ex_rd1", ex_read_data_1, e_rd1);
        chk("ex_rd2", ex_read_data_2, e_rd2);
        chk("ex_imm", ex_immediate, e_imm);
        chk("ex_regs", {ex_rs, ex_rt, ex_rd}, {rs, rt, rd});
        m_valid = e_valid;
        m_ctrl = e_ctrl;
        m_rt = rt;
    endtask

    localparam logic [31:0] LW_R2  = {6'h23, 5'd1, 5'd2, 16'd0};
    localparam logic [31:0] ADD_32 = {6'h00, 5'd2, 5'd4, 5'd3, 11'h020};
    localparam logic [31:0] SW_R2  = {6'h2b, 5'd7, 5'd2, 16'd4};
    localparam logic [31:0] ADDI_9 = {6'h08, 5'd9, 5'd2, 16'd1};
    localparam logic [31:0] NOP_R  = {6'h00, 5'd0, 5'd0, 5'd0, 11'h020};

    initial begin
        logic [5:0]  ops [9];
        logic [31:0] ins, r;
        model_reset();
        ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h23, 6'h2b, 6'h3f};

        // Reset: outputs zero, writeback ignored.
        wb_reg_write = 1;
        wb_write_register = 5'd5;
        wb_write_data = 32'h1234_5678;
        instruction = LW_R2;
        instr_valid = 1;
        #1;
        check_zero("rst0");
        @(posedge clock);
        #1;
        check_zero("rst1");
        wb_reg_write = 0;
        reset = 0;

        // Bypass on r5 while decoding add r6,r5,r0.
        cycle({6'h00, 5'd5, 5'd0, 5'd6, 11'h020}, 1, 1, 5'd5, 32'hAA, 0);
        chk("bypass_r5", ex_read_data_1, 32'h0000_00AA);
        cycle({6'h00, 5'd0, 5'd5, 5'd6, 11'h020}, 1, 1, 5'd0,
              32'hFFFF_FFFF, 0);
        chk("r5_stored", ex_read_data_2, 32'h0000_00AA);
        cycle({6'h00, 5'd0, 5'd0, 5'd6, 11'h020}, 1, 0, 5'd0, 0, 0);
        chk("r0_zero", ex_read_data_1, 0);

        // Load-use on rs.
        cycle(LW_R2, 1, 0, 0, 0, 0);
        cycle(ADD_32, 1, 0, 0, 0, 0);
        chk("lu_stall", last_stall, 1);
        chk("lu_bubble", {ex_valid, ex_ctrl}, 0);
        cycle(ADD_32, 1, 0, 0, 0, 0);
        chk("lu_release", last_stall, 0);
        chk("lu_add_in", {ex_valid, ex_ctrl}, {1'b1, 11'b011_0000_1010});

        // Load-use via rt (sw), and none for addi.
        cycle(LW_R2, 1, 0, 0, 0, 0);
        cycle(SW_R2, 1, 0, 0, 0, 0);
        chk("sw_stall", last_stall, 1);
        cycle(SW_R2, 1, 0, 0, 0, 0);
        cycle(LW_R2, 1, 0, 0, 0, 0);
        cycle(ADDI_9, 1, 0, 0, 0, 0);
        chk("addi_nostall", last_stall, 0);
        chk("addi_valid", ex_valid, 1);

        // Flush together with a hazard: one bubble only.
        cycle(LW_R2, 1, 0, 0, 0, 0);
        cycle(ADD_32, 1, 0, 0, 0, 1);
        chk("fl_bubble", {ex_valid, ex_ctrl}, 0);
        cycle(ADD_32, 1, 0, 0, 0, 0);
        chk("fl_nodouble", last_stall, 0);
        chk("fl_next_valid", ex_valid, 1);

        // Unknown opcode decodes to zero controls but stays valid.
        cycle({6'h3f, 26'h123_4567}, 1, 0, 0, 0, 0);
        chk("bad_op", {ex_valid, ex_ctrl}, {1'b1, 11'd0});

        // Immediates.
        cycle({6'h0c, 5'd1, 5'd2, 16'h8001}, 1, 0, 0, 0, 0);
        chk("andi_imm", ex_immediate, 32'h0000_8001);
        cycle({6'h08, 5'd1, 5'd2, 16'h8001}, 1, 0, 0, 0, 0);
        chk("addi_imm", ex_immediate, 32'hFFFF_8001);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), r[15:0]};
            cycle(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) == 0);
        end

        // Fill the whole register file, then reset mid-stall.
        for (int i = 1; i < 32; i++)
            cycle(NOP_R, 1, 1, 5'(i), $urandom | 32'h1, 0);
        cycle(LW_R2, 1, 0, 0, 0, 0);
        instruction = ADD_32;
        #1;
        chk("pre_rst_stall", stall_out, 1);
        #1;
        reset = 1;
        #1;
        check_zero("rst_mid");
        @(posedge clock);
        #1;
        check_zero("rst_mid_edge");
        reset = 0;
        model_reset();
        for (int i = 1; i < 32; i++) begin
            cycle({6'h00, 5'(i), 5'(i), 5'd1, 11'h020}, 1, 0, 0, 0, 0);
            chk("rf_cleared", {ex_read_data_1, ex_read_data_2}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
